// File: rtl/trace_checker.sv
// -----------------------------------------------------------------------------
// trace_checker
//
// Self-checking monitor that sits beside the processor datapath. A table of
// expected per-cycle observation vectors is loaded while the checker is idle.
// During a run, each `sample` strobe compares the live taps against the table
// entry at cur_idx. The checker accumulates a saturating mismatch count and
// records the first failing vector.
//
// Each table entry holds {skip, mask[CHANNELS], data[CHANNELS*DATA_W]}.
//   - skip marks a don't-care cycle, such as a jump or a taken branch.
//   - mask selects which channels take part in the comparison (1 = compare).
//   - Channel c occupies bits [c*DATA_W +: DATA_W] of data and obs.
//
// Ports
//   clock            single clock, rising edge
//   reset            asynchronous, active-low reset
//   load_en          write one table entry this cycle (IDLE/DONE only)
//   load_addr        entry to write; addresses >= DEPTH are ignored
//   load_data        expected channel values for the entry
//   load_mask        per-channel compare enable
//   load_skip        entry is a don't-care cycle
//   num_vectors      vectors in the run, clamped to DEPTH, sampled at start
//   start            begin a run (ignored while a run is in progress)
//   sample           one observation this cycle
//   obs              live datapath taps
//   busy             run in progress
//   done             run finished
//   pass             done with zero errors
//   err_count        saturating mismatch count (one per mismatching channel)
//   first_err_valid  a mismatch has been captured
//   first_err_idx    vector index of the first mismatch
//   first_err_mask   channels that mismatched at first_err_idx
//   cur_idx          next vector to be checked
// -----------------------------------------------------------------------------
module trace_checker #(
   parameter int DATA_W   = 32,
   parameter int CHANNELS = 3,
   parameter int DEPTH    = 64,
   parameter int CNT_W    = 16,
   parameter int IDX_W    = $clog2(DEPTH)
) (
   input  logic                         clock,
   input  logic                         reset,

   input  logic                         load_en,
   input  logic [IDX_W-1:0]             load_addr,
   input  logic [CHANNELS*DATA_W-1:0]   load_data,
   input  logic [CHANNELS-1:0]          load_mask,
   input  logic                         load_skip,

   input  logic [IDX_W:0]               num_vectors,
   input  logic                         start,
   input  logic                         sample,
   input  logic [CHANNELS*DATA_W-1:0]   obs,

   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic [CNT_W-1:0]             err_count,
   output logic                         first_err_valid,
   output logic [IDX_W-1:0]             first_err_idx,
   output logic [CHANNELS-1:0]          first_err_mask,
   output logic [IDX_W-1:0]             cur_idx
);

   // Width needed to hold a per-sample popcount of 0..CHANNELS.
   localparam int PC_W  = $clog2(CHANNELS + 1);

   // Wide enough that err_count + popcount can never wrap before it is clamped.
   localparam int SUM_W = CNT_W + PC_W;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [IDX_W:0]   DEPTH_N = (IDX_W + 1)'(DEPTH);
   localparam logic [IDX_W:0]   LEN_ONE = (IDX_W + 1)'(1);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // Expected-vector table.
   logic [CHANNELS*DATA_W-1:0] tbl_data [DEPTH];
   logic [CHANNELS-1:0]        tbl_mask [DEPTH];
   logic                       tbl_skip [DEPTH];

   // Run length latched at start (1..DEPTH for a real run).
   logic [IDX_W:0]       run_len;
   logic [IDX_W:0]       start_len;

   // start accepted this cycle
   logic                 launch;

   // sample accepted this cycle
   logic                 step;

   // cur_idx is the final vector of the run
   logic                 last;

   logic                 tbl_we;
   logic [CHANNELS-1:0]  mism;
   logic [PC_W-1:0]      mism_cnt;
   logic [SUM_W-1:0]     err_sum;
   logic [CNT_W-1:0]     err_next;

   // ---------------------------------------------------------------------------
   // Table write port. The table is locked while a run is in progress so that
   // the expected data cannot change under the comparison.
   // ---------------------------------------------------------------------------
   assign tbl_we = load_en && (state != RUN) && (int'(load_addr) < DEPTH);

   // NOTE: the table carries no reset. Its contents are only meaningful after
   // a load, and leaving the reset off lets it map onto plain storage.
   always_ff @(posedge clock) begin
      if (tbl_we) begin
         tbl_data[load_addr] <= load_data;
         tbl_mask[load_addr] <= load_mask;
         tbl_skip[load_addr] <= load_skip;
      end
   end

   // ---------------------------------------------------------------------------
   // Compare the live taps against the entry at cur_idx.
   // The table read is combinational.
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default before any conditional
   // logic, so no path leaves a value held and no latch is inferred.
   always_comb begin
      mism     = '0;
      mism_cnt = '0;
      if (!tbl_skip[cur_idx]) begin
         for (int c = 0; c < CHANNELS; c++) begin
            mism[c] = tbl_mask[cur_idx][c] &&
                      (obs[c*DATA_W +: DATA_W] != tbl_data[cur_idx][c*DATA_W +: DATA_W]);
         end
      end
      for (int c = 0; c < CHANNELS; c++) begin
         mism_cnt = mism_cnt + PC_W'(mism[c]);
      end
   end

   // The saturating add is done at full width and then clamped.
   // The counter therefore sticks at all-ones instead of wrapping.
   assign err_sum  = SUM_W'(err_count) + SUM_W'(mism_cnt);
   assign err_next = (err_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : err_sum[CNT_W-1:0];

   // ---------------------------------------------------------------------------
   // Run control qualifiers
   // ---------------------------------------------------------------------------
   assign start_len = (num_vectors > DEPTH_N) ? DEPTH_N : num_vectors;
   assign launch    = start && (state != RUN);
   assign step      = sample && (state == RUN);
   assign last      = ({1'b0, cur_idx} == (run_len - LEN_ONE));

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   // NOTE: state registers use non-blocking assignments. Every flop then
   // samples pre-edge values, whatever order the processes evaluate in.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next state and status outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      pass       = 1'b0;

      case (state)
         IDLE, DONE: begin
            // A zero-length run completes without ever entering RUN.
            if (start) begin
               state_next = (start_len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (sample && last) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase

      busy = (state == RUN);
      done = (state == DONE);
      pass = (state == DONE) && (err_count == '0);
   end

   // ---------------------------------------------------------------------------
   // Run datapath: index, error count, first-failure capture
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         run_len         <= '0;
         cur_idx         <= '0;
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_idx   <= '0;
         first_err_mask  <= '0;
      end else if (launch) begin
         run_len         <= start_len;
         cur_idx         <= '0;
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_idx   <= '0;
         first_err_mask  <= '0;
      end else if (step) begin
         err_count <= err_next;
         if ((mism != '0) && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_idx   <= cur_idx;
            first_err_mask  <= mism;
         end
         // After the final vector, cur_idx holds at run_len-1.
         if (!last) begin
            cur_idx <= cur_idx + IDX_ONE;
         end
      end
   end

endmodule

// File: tb/tb_trace_checker.sv
// -----------------------------------------------------------------------------
// tb_trace_checker
//
// Bench for trace_checker, with three parts:
//   - Directed table-driven scenarios. Each scenario is a list of
//     {data, mask, skip, obs, expected mismatch} records.
//   - Hand-written multi-cycle corner sequences.
//   - Randomised runs checked against a table-level reference model.
//
// A second instance with CNT_W=2 shares the stimulus and covers counter
// saturation.
// -----------------------------------------------------------------------------
module tb_trace_checker;

   localparam int DATA_W   = 32;
   localparam int CHANNELS = 3;
   localparam int DEPTH    = 64;
   localparam int CNT_W    = 16;
   localparam int IDX_W    = 6;
   localparam int W        = CHANNELS * DATA_W;

   localparam int DEPTH2   = 8;
   localparam int IDX2_W   = 3;
   localparam int CNT2_W   = 2;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic                 load_en = 1'b0;
   logic [IDX_W-1:0]     load_addr = '0;
   logic [W-1:0]         load_data = '0;
   logic [CHANNELS-1:0]  load_mask = '0;
   logic                 load_skip = 1'b0;
   logic [IDX_W:0]       num_vectors = '0;
   logic                 start = 1'b0;
   logic                 sample = 1'b0;
   logic [W-1:0]         obs = '0;

   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [CNT_W-1:0]     err_count;
   logic                 first_err_valid;
   logic [IDX_W-1:0]     first_err_idx;
   logic [CHANNELS-1:0]  first_err_mask;
   logic [IDX_W-1:0]     cur_idx;

   logic                 busy_s;
   logic                 done_s;
   logic                 pass_s;
   logic [CNT2_W-1:0]    err_count_s;
   logic                 first_err_valid_s;
   logic [IDX2_W-1:0]    first_err_idx_s;
   logic [CHANNELS-1:0]  first_err_mask_s;
   logic [IDX2_W-1:0]    cur_idx_s;

   int n_compared   = 0;
   int n_mismatched = 0;

   trace_checker #(
      .DATA_W   (DATA_W),
      .CHANNELS (CHANNELS),
      .DEPTH    (DEPTH),
      .CNT_W    (CNT_W),
      .IDX_W    (IDX_W)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .load_en         (load_en),
      .load_addr       (load_addr),
      .load_data       (load_data),
      .load_mask       (load_mask),
      .load_skip       (load_skip),
      .num_vectors     (num_vectors),
      .start           (start),
      .sample          (sample),
      .obs             (obs),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .err_count       (err_count),
      .first_err_valid (first_err_valid),
      .first_err_idx   (first_err_idx),
      .first_err_mask  (first_err_mask),
      .cur_idx         (cur_idx)
   );

   trace_checker #(
      .DATA_W   (DATA_W),
      .CHANNELS (CHANNELS),
      .DEPTH    (DEPTH2),
      .CNT_W    (CNT2_W),
      .IDX_W    (IDX2_W)
   ) dut_sat (
      .clock           (clock),
      .reset           (reset),
      .load_en         (load_en),
      .load_addr       (load_addr[IDX2_W-1:0]),
      .load_data       (load_data),
      .load_mask       (load_mask),
      .load_skip       (load_skip),
      .num_vectors     (num_vectors[IDX2_W:0]),
      .start           (start),
      .sample          (sample),
      .obs             (obs),
      .busy            (busy_s),
      .done            (done_s),
      .pass            (pass_s),
      .err_count       (err_count_s),
      .first_err_valid (first_err_valid_s),
      .first_err_idx   (first_err_idx_s),
      .first_err_mask  (first_err_mask_s),
      .cur_idx         (cur_idx_s)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [W-1:0]        data;
      logic [CHANNELS-1:0] mask;
      logic                skip;
      logic [W-1:0]        obs;
      logic [CHANNELS-1:0] exp_mism;
   } vec_t;

   vec_t vecs [16];

   // Reference-model copy of the table, used by the randomised runs.
   logic [W-1:0]        m_data [DEPTH];
   logic [CHANNELS-1:0] m_mask [DEPTH];
   logic                m_skip [DEPTH];

   function automatic logic [W-1:0] pk(input logic [31:0] c0,
                                       input logic [31:0] c1,
                                       input logic [31:0] c2);
      return {c2, c1, c0};
   endfunction

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance one clock edge. Inputs are then driven, and outputs read,
   // 1 ns after that edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load_entry(input int addr,
                             input logic [W-1:0] data,
                             input logic [CHANNELS-1:0] mask,
                             input logic skip);
      load_addr = IDX_W'(addr);
      load_data = data;
      load_mask = mask;
      load_skip = skip;
      load_en   = 1'b1;
      tick();
      load_en   = 1'b0;
   endtask

   task automatic do_start(input int n);
      num_vectors = (IDX_W + 1)'(n);
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   task automatic do_sample(input logic [W-1:0] o);
      obs    = o;
      sample = 1'b1;
      tick();
      sample = 1'b0;
   endtask

   // Load n records from vecs[base..], run them with `stall` idle cycles
   // before each sample, and check the result.
   // Expected values come from each record's exp_mism field.
   task automatic run_vectors(input string tag,
                              input int base,
                              input int n,
                              input int stall);
      int e;
      bit fv;
      int fi;
      logic [CHANNELS-1:0] fm;

      e  = 0;
      fv = 0;
      fi = 0;
      fm = '0;

      for (int i = 0; i < n; i++) begin
         load_entry(i, vecs[base+i].data, vecs[base+i].mask, vecs[base+i].skip);
      end
      do_start(n);
      check({tag, "_busy_at_start"}, busy, 1);
      check({tag, "_cur_idx_at_start"}, cur_idx, 0);

      for (int i = 0; i < n; i++) begin
         if (stall > 0) begin
            obs = {3{32'hDEADBEEF}};
            repeat (stall) tick();
            check({tag, "_busy_in_stall"}, busy, 1);
            check({tag, "_cur_idx_in_stall"}, cur_idx, i);
         end
         do_sample(vecs[base+i].obs);
         if (!fv && vecs[base+i].exp_mism != '0) begin
            fv = 1;
            fi = i;
            fm = vecs[base+i].exp_mism;
         end
         e += $countones(vecs[base+i].exp_mism);
         if (i < n - 1) begin
            check({tag, "_cur_idx_step"}, cur_idx, i + 1);
         end
      end

      check({tag, "_done"}, done, 1);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_pass"}, pass, (e == 0));
      check({tag, "_err_count"}, err_count, e);
      check({tag, "_first_err_valid"}, first_err_valid, fv);
      check({tag, "_first_err_idx"}, first_err_idx, fi);
      check({tag, "_first_err_mask"}, first_err_mask, fm);
      check({tag, "_cur_idx_held"}, cur_idx, n - 1);
   endtask

   // Randomised runs against the table-level model.
   // The model applies the checking rules directly: per-channel masked
   // inequality, skip entries ignored, a saturating sum, and the first failure
   // recorded.
   task automatic run_random(input int runs);
      for (int r = 0; r < runs; r++) begin
         int n;
         int e;
         bit fv;
         int fi;
         logic [CHANNELS-1:0] fm;
         logic [CHANNELS-1:0] m;
         logic [W-1:0] o;

         n  = $urandom_range(1, 20);
         e  = 0;
         fv = 0;
         fi = 0;
         fm = '0;

         for (int i = 0; i < n; i++) begin
            m_data[i] = pk($urandom, $urandom, $urandom);
            m_mask[i] = CHANNELS'($urandom_range(0, 7));
            m_skip[i] = ($urandom_range(0, 5) == 0);
            load_entry(i, m_data[i], m_mask[i], m_skip[i]);
         end
         do_start(n);

         for (int i = 0; i < n; i++) begin
            obs = pk($urandom, $urandom, $urandom);
            repeat ($urandom_range(0, 2)) tick();

            o = m_data[i];
            for (int c = 0; c < CHANNELS; c++) begin
               if ($urandom_range(0, 3) == 0) begin
                  o[c*DATA_W +: DATA_W] = o[c*DATA_W +: DATA_W] ^ (32'h1 << $urandom_range(0, 31));
               end
            end

            m = '0;
            if (!m_skip[i]) begin
               for (int c = 0; c < CHANNELS; c++) begin
                  if (m_mask[i][c] && (o[c*DATA_W +: DATA_W] != m_data[i][c*DATA_W +: DATA_W])) begin
                     m[c] = 1'b1;
                  end
               end
            end
            if (!fv && m != '0) begin
               fv = 1;
               fi = i;
               fm = m;
            end
            e = (e + $countones(m) > 65535) ? 65535 : e + $countones(m);

            do_sample(o);
            check("rnd_err_count_step", err_count, e);
            check("rnd_cur_idx_step", cur_idx, (i < n - 1) ? i + 1 : n - 1);
         end

         check("rnd_done", done, 1);
         check("rnd_pass", pass, (e == 0));
         check("rnd_first_err_valid", first_err_valid, fv);
         check("rnd_first_err_idx", first_err_idx, fi);
         check("rnd_first_err_mask", first_err_mask, fm);
      end
   endtask

   initial begin
      // Scenario A: every entry matches its observation.
      vecs[0] = '{pk(32'h28400005, 0, 5), 3'b111, 1'b0, pk(32'h28400005, 0, 5), 3'b000};
      vecs[1] = '{pk(32'h28800003, 0, 3), 3'b111, 1'b0, pk(32'h28800003, 0, 3), 3'b000};
      vecs[2] = '{pk(32'h00C22000, 5, 3), 3'b111, 1'b0, pk(32'h00C22000, 5, 3), 3'b000};
      vecs[3] = '{pk(32'h28C60000, 8, 0), 3'b111, 1'b0, pk(32'h28C60000, 8, 0), 3'b000};

      // Scenario B: entry 2 is a don't-care cycle with garbage observations.
      for (int i = 0; i < 4; i++) begin
         vecs[4+i] = vecs[i];
      end
      vecs[6].skip = 1'b1;
      vecs[6].obs  = {3{32'hDEADBEEF}};

      // Scenario C: entry 1 fails on ch1; entry 3 fails on ch0 and ch2.
      for (int i = 0; i < 4; i++) begin
         vecs[8+i] = vecs[i];
      end
      vecs[9].data      = pk(32'h28800003, 5, 3);
      vecs[9].obs       = pk(32'h28800003, 3, 3);
      vecs[9].exp_mism  = 3'b010;
      vecs[11].obs      = pk(32'h28C60001, 8, 1);
      vecs[11].exp_mism = 3'b101;

      // Scenario D: entry 0 compares ch0 only; ch1 and ch2 are wrong.
      for (int i = 0; i < 4; i++) begin
         vecs[12+i] = vecs[i];
      end
      vecs[12].mask = 3'b001;
      vecs[12].obs  = pk(32'h28400005, 7, 9);

      // Power-on reset
      #1 reset = 1'b0;
      #1;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_pass", pass, 0);
      check("reset_err_count", err_count, 0);
      check("reset_first_err_valid", first_err_valid, 0);
      check("reset_cur_idx", cur_idx, 0);
      repeat (2) tick();
      reset = 1'b1;
      tick();

      run_vectors("all_pass", 0, 4, 0);

      // Load lockout: a write during RUN must not change entry 1.
      do_start(4);
      do_sample(vecs[0].obs);
      load_addr = IDX_W'(1);
      load_data = pk(1, 2, 3);
      load_mask = '1;
      load_skip = 1'b0;
      load_en   = 1'b1;
      obs       = vecs[1].obs;
      sample    = 1'b1;
      tick();
      load_en   = 1'b0;
      sample    = 1'b0;
      do_sample(vecs[2].obs);
      do_sample(vecs[3].obs);
      check("lockout_run_done", done, 1);
      check("lockout_run_err", err_count, 0);
      do_start(4);
      for (int i = 0; i < 4; i++) begin
         do_sample(vecs[i].obs);
      end
      check("lockout_rerun_pass", pass, 1);
      check("lockout_rerun_err", err_count, 0);

      run_vectors("skip", 4, 4, 0);
      run_vectors("mismatch", 8, 4, 0);
      run_vectors("mask_stall", 12, 4, 5);

      // Load and start in the same cycle: the run sees the new entry 0.
      load_addr   = '0;
      load_data   = pk(32'h11111111, 32'h22222222, 32'h33333333);
      load_mask   = '1;
      load_skip   = 1'b0;
      load_en     = 1'b1;
      num_vectors = (IDX_W + 1)'(1);
      start       = 1'b1;
      tick();
      load_en     = 1'b0;
      start       = 1'b0;
      check("load_start_busy", busy, 1);
      do_sample(pk(32'h11111111, 32'h22222222, 32'h33333333));
      check("load_start_done", done, 1);
      check("load_start_err", err_count, 0);

      // A zero-length run is done and passing one clock after start.
      do_start(0);
      check("zero_done", done, 1);
      check("zero_pass", pass, 1);
      check("zero_busy", busy, 0);
      check("zero_err", err_count, 0);

      // num_vectors above DEPTH is clamped: exactly DEPTH samples are checked.
      for (int i = 0; i < DEPTH; i++) begin
         load_entry(i, pk(i, i * 3, ~i), 3'b111, 1'b0);
      end
      do_start(DEPTH + 5);
      for (int i = 0; i < DEPTH; i++) begin
         do_sample((i == DEPTH - 1) ? pk(i ^ 1, i * 3, ~i) : pk(i, i * 3, ~i));
         if (i == DEPTH - 2) begin
            check("clamp_busy_before_last", busy, 1);
         end
      end
      check("clamp_done", done, 1);
      check("clamp_err", err_count, 1);
      check("clamp_first_idx", first_err_idx, DEPTH - 1);
      check("clamp_first_mask", first_err_mask, 3'b001);
      check("clamp_cur_idx", cur_idx, DEPTH - 1);
      do_sample(pk(0, 0, 0));
      check("done_ignores_sample_err", err_count, 1);
      check("done_ignores_sample_done", done, 1);

      // Saturation: 5 mismatches total. The CNT_W=2 instance stops at 3.
      load_entry(0, pk(1, 2, 3), 3'b111, 1'b0);
      load_entry(1, pk(4, 5, 6), 3'b111, 1'b0);
      do_start(2);
      do_sample(pk(0, 0, 0));
      do_sample(pk(4, 0, 0));
      check("sat_wide_err", err_count, 5);
      check("sat_narrow_err", err_count_s, 3);
      check("sat_narrow_done", done_s, 1);
      check("sat_narrow_pass", pass_s, 0);
      check("sat_narrow_first_mask", first_err_mask_s, 3'b111);

      // Reset mid-run clears the outputs asynchronously, with no clock edge.
      for (int i = 0; i < 4; i++) begin
         load_entry(i, vecs[8+i].data, vecs[8+i].mask, vecs[8+i].skip);
      end
      do_start(4);
      do_sample(vecs[8].obs);
      do_sample(vecs[9].obs);
      check("pre_reset_err", err_count, 1);
      #2 reset = 1'b0;
      #1;
      check("midrun_reset_busy", busy, 0);
      check("midrun_reset_done", done, 0);
      check("midrun_reset_err", err_count, 0);
      check("midrun_reset_cur_idx", cur_idx, 0);
      check("midrun_reset_first_valid", first_err_valid, 0);
      tick();
      reset = 1'b1;
      tick();

      run_random(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
